// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared size encodings, FSM states and alignment check for the dmem arbiter
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE_WR,
    ST_RESP
  } state_t;

  // Natural alignment: the low address bits must be a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_H:    is_misaligned = addr_lo[0];
      SZ_W:    is_misaligned = |addr_lo[1:0];
      SZ_D:    is_misaligned = |addr_lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational load lane extract/extend and store lane merge
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_rdata,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_load_data,
  output logic [63:0] o_merged
);

  logic [5:0]  w_shamt;
  logic [63:0] w_lane;
  logic [63:0] w_size_mask;
  logic [63:0] w_mask;

  assign w_shamt = {i_addr_lo, 3'b000};
  assign w_lane  = i_rdata >> w_shamt;

  always_comb begin
    o_load_data = w_lane;
    w_size_mask = '1;
    case (i_size)
      SZ_B: begin
        o_load_data = {{56{~i_unsigned & w_lane[7]}}, w_lane[7:0]};
        w_size_mask = 64'h0000_0000_0000_00FF;
      end
      SZ_H: begin
        o_load_data = {{48{~i_unsigned & w_lane[15]}}, w_lane[15:0]};
        w_size_mask = 64'h0000_0000_0000_FFFF;
      end
      SZ_W: begin
        o_load_data = {{32{~i_unsigned & w_lane[31]}}, w_lane[31:0]};
        w_size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: ;
    endcase
  end

  // Store data arrives right-aligned; move it into its lane and splice over the old word.
  assign w_mask   = w_size_mask << w_shamt;
  assign o_merged = (i_rdata & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule

// File: rtl/dmem_arbiter_lsu.sv
// rtl/dmem_arbiter_lsu.sv - two-port round-robin arbiter and sub-word sequencer for the doubleword data memory
// Optional saturating statistics counters under `define DMEM_ARB_STATS_EN.
module dmem_arbiter_lsu
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [63:0] p0_req_addr,
  input  logic [63:0] p0_req_wdata,
  input  logic        p0_req_we,
  input  logic [1:0]  p0_req_size,
  input  logic        p0_req_unsigned,
  output logic        p0_rsp_valid,
  output logic [63:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [63:0] p1_req_addr,
  input  logic [63:0] p1_req_wdata,
  input  logic        p1_req_we,
  input  logic [1:0]  p1_req_size,
  input  logic        p1_req_unsigned,
  output logic        p1_rsp_valid,
  output logic [63:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_grant0,
  output logic [31:0] stat_grant1,
  output logic [31:0] stat_err,
  output logic [31:0] stat_rmw
`endif
);

  state_t      r_state;
  logic        r_rr_ptr;
  logic        r_owner;
  logic        r_we;
  logic        r_unsigned;
  logic        r_err;
  logic [1:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_data;

  logic        w_idle;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_any_grant;
  logic [63:0] w_req_addr;
  logic [63:0] w_req_wdata;
  logic        w_req_we;
  logic [1:0]  w_req_size;
  logic        w_req_unsigned;
  logic        w_req_err;
  logic        w_resp;
  logic        w_dword_st;
  logic [63:0] w_load_data;
  logic [63:0] w_merged;

  assign w_idle      = (r_state == ST_IDLE) && !reset;
  assign w_grant0    = w_idle && p0_req_valid && (!p1_req_valid || !r_rr_ptr);
  assign w_grant1    = w_idle && p1_req_valid && (!p0_req_valid || r_rr_ptr);
  assign w_any_grant = w_grant0 || w_grant1;

  assign p0_req_ready = w_grant0;
  assign p1_req_ready = w_grant1;

  assign w_req_addr     = w_grant1 ? p1_req_addr     : p0_req_addr;
  assign w_req_wdata    = w_grant1 ? p1_req_wdata    : p0_req_wdata;
  assign w_req_we       = w_grant1 ? p1_req_we       : p0_req_we;
  assign w_req_size     = w_grant1 ? p1_req_size     : p0_req_size;
  assign w_req_unsigned = w_grant1 ? p1_req_unsigned : p0_req_unsigned;
  assign w_req_err      = is_misaligned(w_req_addr[2:0], w_req_size)
                       || (w_req_addr[63:3] >= 61'(DEPTH_WORDS));

  dmem_lane_align u_lane_align (
    .i_addr_lo   (r_addr[2:0]),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_rdata     (mem_rdata),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  assign w_dword_st = r_we && (r_size == SZ_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= 1'b0;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= SZ_B;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_grant) begin
            r_addr     <= w_req_addr;
            r_wdata    <= w_req_wdata;
            r_we       <= w_req_we;
            r_size     <= w_req_size;
            r_unsigned <= w_req_unsigned;
            r_owner    <= w_grant1;
            r_err      <= w_req_err;
            r_data     <= '0;
            // The pointer only moves on contention, handing priority to the loser.
            if (p0_req_valid && p1_req_valid) r_rr_ptr <= ~w_grant1;
            r_state    <= w_req_err ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_we) begin
            r_data  <= w_load_data;
            r_state <= ST_RESP;
          end else if (w_dword_st) begin
            r_state <= ST_RESP;
          end else begin
            r_data  <= w_merged;
            r_state <= ST_MERGE_WR;
          end
        end
        ST_MERGE_WR: begin
          r_data  <= '0;
          r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_resp       = (r_state == ST_RESP);
  assign p0_rsp_valid = w_resp && !r_owner;
  assign p1_rsp_valid = w_resp && r_owner;
  assign p0_rsp_rdata = p0_rsp_valid ? r_data : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? r_data : '0;
  assign p0_rsp_err   = p0_rsp_valid && r_err;
  assign p1_rsp_err   = p1_rsp_valid && r_err;

  // Gating with reset keeps an interrupted merge from landing on its write edge.
  assign mem_read  = !reset && (r_state == ST_ACCESS) && !w_dword_st;
  assign mem_write = !reset && (((r_state == ST_ACCESS) && w_dword_st) || (r_state == ST_MERGE_WR));
  assign mem_addr  = {r_addr[63:3], 3'b000};
  assign mem_wdata = (r_state == ST_MERGE_WR) ? r_data : r_wdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_grant0;
  logic [31:0] r_stat_grant1;
  logic [31:0] r_stat_err;
  logic [31:0] r_stat_rmw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_grant0 <= '0;
      r_stat_grant1 <= '0;
      r_stat_err    <= '0;
      r_stat_rmw    <= '0;
    end else begin
      if (w_grant0 && (r_stat_grant0 != '1)) r_stat_grant0 <= r_stat_grant0 + 32'd1;
      if (w_grant1 && (r_stat_grant1 != '1)) r_stat_grant1 <= r_stat_grant1 + 32'd1;
      if (w_any_grant && w_req_err && (r_stat_err != '1)) r_stat_err <= r_stat_err + 32'd1;
      if (w_any_grant && !w_req_err && w_req_we && (w_req_size != SZ_D) && (r_stat_rmw != '1))
        r_stat_rmw <= r_stat_rmw + 32'd1;
    end
  end

  assign stat_grant0 = r_stat_grant0;
  assign stat_grant1 = r_stat_grant1;
  assign stat_err    = r_stat_err;
  assign stat_rmw    = r_stat_rmw;
`endif

endmodule
